// File: rtl/fragmented_broadcaster.sv
// Captures one word and replicates it to every way, completing each way's handshake independently.
// Optional FRAG_BROADCASTER_COUNT_EN adds a 16-bit pkt_count of completed broadcasts.
module fragmented_broadcaster #(
  parameter int unsigned WIRE = 3,
  parameter int unsigned BUS  = 1,
  parameter int unsigned WAY  = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [2**(BUS+WIRE)-1:0]            in_data,
  input  logic                                in_valid,
  input  logic [2**WAY-1:0]                   in_mask,
  output logic                                in_ready,
  output logic [2**(BUS+WAY+WIRE)-1:0]        out_data,
  output logic [2**WAY-1:0]                   out_valid,
  input  logic [2**WAY-1:0]                   out_ready,
  output logic                                busy
`ifdef FRAG_BROADCASTER_COUNT_EN
  ,
  output logic [15:0]                         pkt_count
`endif
);

  localparam int unsigned NW = 2**WAY;
  localparam int unsigned DW = 2**(BUS+WIRE);

  typedef enum logic [0:0] {StIdle, StBcast} state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   pending_q, pending_d;
  logic [DW-1:0]   word_q, word_d;
  logic [NW-1:0]   remaining;
  logic            transfer;
  logic            done;

  // Ways still outstanding after this cycle's handshakes.
  assign remaining = pending_q & ~out_ready;
  assign transfer  = in_valid & in_ready;

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      in_ready = (state_q == StIdle) || (remaining == '0);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    word_d    = word_q;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (transfer && (in_mask != '0)) begin
          state_d   = StBcast;
          pending_d = in_mask;
          word_d    = in_data;
        end
      end
      StBcast: begin
        pending_d = remaining;
        if (remaining == '0) begin
          done = 1'b1;
          if (transfer && (in_mask != '0)) begin
            pending_d = in_mask;
            word_d    = in_data;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      word_q    <= word_d;
    end
  end

  assign busy      = (state_q == StBcast);
  assign out_valid = busy ? pending_q : '0;
  assign out_data  = {NW{word_q}};

`ifdef FRAG_BROADCASTER_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (done) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign pkt_count = count_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_fragmented_broadcaster.sv
// Directed bench for fragmented_broadcaster at WIRE=3, BUS=1, WAY=1.
module tb_fragmented_broadcaster;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic [1:0]  in_mask;
  logic        in_ready;
  logic [31:0] out_data;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic        busy;
`ifdef FRAG_BROADCASTER_COUNT_EN
  logic [15:0] pkt_count;
  logic [15:0] cnt_before;
`endif

  int n_checks;
  int n_errors;

  fragmented_broadcaster #(
    .WIRE(3),
    .BUS (1),
    .WAY (1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_mask  (in_mask),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
`ifdef FRAG_BROADCASTER_COUNT_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_mask   = '0;
    out_ready = '0;

    // Reset state
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Case 1: full broadcast completes immediately
    step();
    in_data   = 16'hB4AA;
    in_mask   = 2'b11;
    in_valid  = 1'b1;
    out_ready = 2'b11;
    #1;
    check("c1_in_ready_idle", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("c1_out_valid", 32'(out_valid), 32'h3);
    check("c1_out_data", out_data, 32'hB4AAB4AA);
    check("c1_busy", 32'(busy), 32'd1);
    step();
    check("c1_idle_busy", 32'(busy), 32'd0);
    check("c1_idle_out_valid", 32'(out_valid), 32'd0);
    check("c1_idle_out_data_kept", out_data, 32'hB4AAB4AA);

    // Case 2: ways complete at different times
    in_data   = 16'h5A3C;
    in_mask   = 2'b11;
    in_valid  = 1'b1;
    out_ready = 2'b01;
    step();
    in_valid = 1'b0;
    #1;
    check("c2_valid_first", 32'(out_valid), 32'h3);
    check("c2_in_ready_first", 32'(in_ready), 32'd0);
    step();
    #1;
    check("c2_valid_second", 32'(out_valid), 32'h2);
    check("c2_in_ready_second", 32'(in_ready), 32'd0);
    step();
    #1;
    check("c2_valid_third", 32'(out_valid), 32'h2);
    check("c2_busy_third", 32'(busy), 32'd1);
    out_ready = 2'b10;
    #1;
    check("c2_in_ready_final", 32'(in_ready), 32'd1);
    check("c2_out_data_held", out_data, 32'h5A3C5A3C);
    step();
    check("c2_busy_done", 32'(busy), 32'd0);
    check("c2_valid_done", 32'(out_valid), 32'd0);

    // Case 3: back-to-back words, no bubble
    out_ready = 2'b11;
    in_data   = 16'h1122;
    in_mask   = 2'b11;
    in_valid  = 1'b1;
    step();
    check("c3_w0_data", out_data, 32'h11221122);
    check("c3_w0_valid", 32'(out_valid), 32'h3);
    check("c3_w0_in_ready", 32'(in_ready), 32'd1);
    in_data = 16'h3344;
    step();
    in_valid = 1'b0;
    check("c3_w1_data", out_data, 32'h33443344);
    check("c3_w1_valid", 32'(out_valid), 32'h3);
    step();
    check("c3_idle_busy", 32'(busy), 32'd0);

    // Case 4: zero mask discards the word
`ifdef FRAG_BROADCASTER_COUNT_EN
    cnt_before = pkt_count;
`endif
    in_data  = 16'hFFFF;
    in_mask  = 2'b00;
    in_valid = 1'b1;
    #1;
    check("c4_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("c4_out_valid", 32'(out_valid), 32'd0);
    check("c4_busy", 32'(busy), 32'd0);
    check("c4_out_data_kept", out_data, 32'h33443344);
`ifdef FRAG_BROADCASTER_COUNT_EN
    check("c4_pkt_count", 32'(pkt_count), 32'(cnt_before));
`endif

    // Case 5: reset in mid-broadcast
    out_ready = 2'b00;
    in_data   = 16'hABCD;
    in_mask   = 2'b11;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check("c5_valid_before", 32'(out_valid), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    check("c5_rst_out_valid", 32'(out_valid), 32'd0);
    check("c5_rst_out_data", out_data, 32'd0);
    check("c5_rst_busy", 32'(busy), 32'd0);
    check("c5_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    #2;
    rst_n     = 1'b1;
    out_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("c5_no_stale_valid", 32'(out_valid), 32'd0);
      check("c5_no_stale_data", out_data, 32'd0);
    end

`ifdef FRAG_BROADCASTER_COUNT_EN
    // Case 6: counter wraps after 65537 completions
    check("c6_count_start", 32'(pkt_count), 32'd0);
    in_mask   = 2'b11;
    out_ready = 2'b11;
    in_valid  = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_data = 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("c6_count_wrap", 32'(pkt_count), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fragmented_broadcaster.md
FRAGMENTED_BROADCASTER -- requirements
Module: fragmented_broadcaster

Interface
REQ-001 The block SHALL have parameter WIRE, default 3: log2 of fragment width in bits.
REQ-002 The block SHALL have parameter BUS, default 1: log2 of fragments per word.
REQ-003 The block SHALL have parameter WAY, default 1: log2 of output ways; NW = 2**WAY.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port in_data, input, 2**(BUS+WIRE) bits: word of 2**BUS fragments; fragment f occupies bits [(f+1)*2**WIRE-1 : f*2**WIRE].
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data is offered.
REQ-008 The block SHALL have port in_mask, input, NW bits: bit k set means way k receives this word.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-010 The block SHALL have port out_data, output, 2**(BUS+WAY+WIRE) bits: way k slice is bits [(k+1)*2**(BUS+WIRE)-1 : k*2**(BUS+WIRE)].
REQ-011 The block SHALL have port out_valid, output, NW bits: per-way valid.
REQ-012 The block SHALL have port out_ready, input, NW bits: per-way ready.
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state BCAST.

Function
REQ-014 An input transfer SHALL occur on a rising clk edge when in_valid and in_ready are both 1; in_data and in_mask are captured at that edge.
REQ-015 The FSM SHALL have two states, IDLE and BCAST; in IDLE, in_ready = 1 and out_valid = 0.
REQ-016 On a transfer with in_mask != 0, the FSM SHALL go to BCAST with pending = in_mask and the word held.
REQ-017 On a transfer with in_mask == 0, the word SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-018 In BCAST, out_valid[k] SHALL equal pending[k], and every way slice of out_data SHALL carry the held word replicated, fragment order preserved.
REQ-019 Latency SHALL be one cycle: out_valid asserts in the cycle after the accepting edge.
REQ-020 A way handshake (out_valid[k] & out_ready[k]) SHALL clear pending[k] at the edge; ways complete independently and in any order.
REQ-021 In BCAST, in_ready SHALL be 1 only when (pending & ~out_ready) == 0, i.e. the last pending ways complete this cycle.
REQ-022 A simultaneous final completion and input transfer SHALL load the new word and mask with no bubble; with a zero mask the FSM SHALL return to IDLE.
REQ-023 Final completion without an input transfer SHALL return the FSM to IDLE.
REQ-024 The held word SHALL remain stable while any pending bit is set.
REQ-025 out_data SHALL retain its last value in IDLE.

Reset
REQ-026 While rst_n = 0, regardless of clk, the block SHALL hold state IDLE, pending = 0, out_valid = 0, out_data = 0, busy = 0, and in_ready = 0.
REQ-027 A reset in mid-broadcast SHALL abandon the held word; no way receives it after release.
REQ-028 In the first clk edge after rst_n rises, in_ready SHALL be 1.

Configuration
REQ-029 With macro FRAG_BROADCASTER_COUNT_EN defined, the block SHALL add output pkt_count (16 bits, reset 0), which increments on each return from BCAST completion (REQ-022 or REQ-023) and wraps 65535 -> 0.
REQ-030 Without FRAG_BROADCASTER_COUNT_EN, pkt_count and its counter SHALL be absent; all other behaviour is unchanged.

Verification (WIRE=3, WAY=1, BUS=1)
REQ-031 Case 1: in_data=0xB4AA, in_mask=2'b11, out_ready=2'b11 -> the next cycle out_valid=2'b11 and out_data=0xB4AAB4AA; then IDLE.
REQ-032 Case 2: mask 2'b11, out_ready=2'b01 for 3 cycles then 2'b10 -> way 0 completes at the first edge; in_ready stays 0 until way 1 is ready; busy falls after the way-1 handshake.
REQ-033 Case 3: back-to-back words 0x1122 then 0x3344 with out_ready=2'b11 -> each word valid for one cycle, no idle cycle between them.
REQ-034 Case 4: in_mask=2'b00 with in_valid=1 -> out_valid stays 0, busy stays 0, and pkt_count is unchanged.
REQ-035 Case 5: rst_n pulled low mid-BCAST with out_ready=0 -> out_valid=0 and out_data=0 immediately; after release no stale output appears.
REQ-036 Case 6 (COUNT_EN): 65537 completed broadcasts -> pkt_count=1.
